// File: rtl/fixed_point_divider.sv
// fixed_point_divider
//   Sequential signed fixed-point divider: quotient = a / b in the same Q-format
//   as the operands. The divider uses radix-2 restoring division and produces one
//   quotient bit per clock. The result is truncated toward zero. It saturates on
//   overflow. A zero divisor gives a full-scale result that takes the sign of a.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; aborts a divide in progress
//   start        divide request, honoured only while busy=0
//   a, b         dividend / divisor, sampled on an accepted start
//   busy         high from accepted start through the done cycle
//   done         one-cycle pulse when quotient and flags are valid
//   quotient     signed result, held until the next result
//   overflow     result saturated, held with quotient
//   div_by_zero  b was zero, held with quotient
module fixed_point_divider #(
  parameter int N = 32,
  parameter int Q = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);
  localparam int W  = N + Q;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [N-1:0]  bmag;
  logic [N-1:0]  rem;
  logic [W-1:0]  dq;      // dividend bits shift out the top; quotient bits shift in the bottom
  logic          sign_q, sign_a, bzero;
  logic          accept;
  logic [N:0]    r_shift;
  logic          ge;
  logic [N-1:0]  diff;
  logic [N:0]    sat_res;

  // Unsigned magnitude. The most negative value maps to 2^(N-1) without loss.
  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v);
    logic [N-1:0] u;
    u = v;
    magnitude = v[N-1] ? (~u + 1'b1) : u;
  endfunction

  // Apply the sign and clamp to the signed range. The result is {overflow, value}.
  function automatic logic [N:0] saturate(input logic [W-1:0] mag, input logic neg);
    logic [W-1:0] lim;
    logic [N-1:0] low;
    lim = neg ? (W'(1) << (N-1)) : ((W'(1) << (N-1)) - W'(1));
    low = mag[N-1:0];
    if (mag > lim) saturate = {1'b1, neg ? MINV : MAXV};
    else           saturate = {1'b0, neg ? (~low + 1'b1) : low};
  endfunction

  // A start request is accepted only when the divider is idle. If busy=0, the
  // state is always IDLE.
  assign accept = start && !busy;

  // One restoring step. The partial remainder is always below |b|, so it fits in
  // N bits after the subtraction.
  assign r_shift = {rem, dq[W-1]};
  assign ge      = (r_shift >= {1'b0, bmag});
  assign diff    = r_shift[N-1:0] - bmag;
  assign sat_res = saturate(dq, sign_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (b == '0) ? FIN : RUN;
      RUN:     if (count == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        busy        <= 1'b1;
        count       <= '0;
        overflow    <= 1'b0;
        div_by_zero <= 1'b0;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == RUN) count <= count + 1'b1;
      if (state == FIN) begin
        done <= 1'b1;
        if (bzero) begin
          quotient    <= sign_a ? MINV : MAXV;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
        end else begin
          quotient <= sat_res[N-1:0];
          overflow <= sat_res[N];
        end
      end
    end
  end

  // Datapath: operand capture, then one quotient bit per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      bmag   <= magnitude(b);
      dq     <= {magnitude(a), {Q{1'b0}}};
      rem    <= '0;
      sign_q <= a[N-1] ^ b[N-1];
      sign_a <= a[N-1];
      bzero  <= (b == '0);
    end else if (state == RUN) begin
      rem <= ge ? diff : r_shift[N-1:0];
      dq  <= {dq[W-2:0], ge};
    end
  end
endmodule
